// File: rtl/msrv32_pkg.sv
// Shared msrv32 constants: branch-history counter encodings and the
// opcode[6:2] values the branch predictor and branch unit decode.
package msrv32_pkg;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t BHT_SNT = 2'b00;
   localparam bht_ctr_t BHT_WNT = 2'b01;
   localparam bht_ctr_t BHT_WT  = 2'b10;
   localparam bht_ctr_t BHT_ST  = 2'b11;

   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;

endpackage

// File: rtl/msrv32_sat_ctr2.sv
// 2-bit saturating counter next-state function (no state of its own).
module msrv32_sat_ctr2
   import msrv32_pkg::*;
(
   input  logic [1:0] state,
   input  logic       taken,
   output logic [1:0] state_next
);

   always_comb begin
      state_next = state;
      if (taken && (state != BHT_ST))
         state_next = state + 2'd1;
      else if (!taken && (state != BHT_SNT))
         state_next = state - 2'd1;
   end

endmodule

// File: rtl/msrv32_bht.sv
// Branch history table: PC-indexed 2-bit counters predicting conditional
// branch direction, trained by resolved branches, with mispredict reporting.
module msrv32_bht
   import msrv32_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int CNT_W   = 16
)(
   input  logic             ms_riscv32_mp_clk_in,
   input  logic             ms_riscv32_mp_rst_n_in,
   input  logic             lookup_valid_in,
   input  logic [31:0]      lookup_pc_in,
   output logic             predict_valid_out,
   output logic             predict_taken_out,
   input  logic             resolve_valid_in,
   input  logic [31:0]      resolve_pc_in,
   input  logic [4:0]       resolve_opcode_6_to_2_in,
   input  logic             branch_taken_in,
   input  logic             predicted_taken_in,
   output logic             mispredict_out,
   output logic [CNT_W-1:0] mispredict_count_out
);

   bht_ctr_t         table_reg [ENTRIES];
   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] resolve_idx;
   logic             train_en;
   logic             mismatch;
   bht_ctr_t         ctr_cur;
   bht_ctr_t         ctr_next;

   logic             predict_valid_reg;
   logic             predict_taken_reg;
   logic             mispredict_reg;
   logic [CNT_W-1:0] mispredict_count_reg;

   // Untagged table: only the index bits of either PC matter.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc_in[31:IDX_W+2], lookup_pc_in[1:0],
                             resolve_pc_in[31:IDX_W+2], resolve_pc_in[1:0]};

   assign lookup_idx  = lookup_pc_in[IDX_W+1:2];
   assign resolve_idx = resolve_pc_in[IDX_W+1:2];

   // Jumps are always taken in the branch unit, so only conditional
   // branches are allowed to train or report a mispredict.
   assign train_en = resolve_valid_in && (resolve_opcode_6_to_2_in == OPC_BRANCH);
   assign mismatch = train_en && (branch_taken_in != predicted_taken_in);
   assign ctr_cur  = table_reg[resolve_idx];

   msrv32_sat_ctr2 u_sat_ctr2 (
      .state      (ctr_cur),
      .taken      (branch_taken_in),
      .state_next (ctr_next)
   );

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         for (int i = 0; i < ENTRIES; i++)
            table_reg[i] <= BHT_WNT;
      end else if (train_en) begin
         table_reg[resolve_idx] <= ctr_next;
      end
   end

   // Lookup reads the pre-update table, so a same-index update is not bypassed.
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         predict_valid_reg <= 1'b0;
         predict_taken_reg <= 1'b0;
      end else begin
         predict_valid_reg <= lookup_valid_in;
         if (lookup_valid_in)
            predict_taken_reg <= table_reg[lookup_idx][1];
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         mispredict_reg       <= 1'b0;
         mispredict_count_reg <= '0;
      end else begin
         mispredict_reg <= mismatch;
         if (mismatch && (mispredict_count_reg != {CNT_W{1'b1}}))
            mispredict_count_reg <= mispredict_count_reg + 1'b1;
      end
   end

   assign predict_valid_out    = predict_valid_reg;
   assign predict_taken_out    = predict_taken_reg;
   assign mispredict_out       = mispredict_reg;
   assign mispredict_count_out = mispredict_count_reg;

endmodule
